// File: rtl/mat3_loader.sv
// mat3_loader: assembles packed 3x3 operand matrices A then B from a serial element stream
// Ports: clk, rst_n (async active-low), clear (sync abort), in_data/in_valid/in_ready (element stream),
//        mat_a/mat_b/out_valid/out_ready (matrix pair handshake), elem_idx (next slot), phase (0 A, 1 B, 2 FULL)
module mat3_loader #(
  parameter int ELEM_W = 8,
  parameter int DIM = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [ELEM_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [ELEM_W*DIM*DIM-1:0] mat_a,
  output logic [ELEM_W*DIM*DIM-1:0] mat_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3:0]                elem_idx,
  output logic [1:0]                phase
);
  localparam int NE = DIM * DIM;
  localparam int W = ELEM_W * NE;
  typedef enum logic [1:0] {LOAD_A = 2'd0, LOAD_B = 2'd1, FULL = 2'd2} state_t;
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [W-1:0] mat_a_q, mat_a_d, mat_b_q, mat_b_d;
  logic acc, last;
  always_comb begin
    acc = in_valid && in_ready && !clear;
    last = idx_q == 4'(NE - 1);
    state_d = state_q;
    idx_d = idx_q;
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;
    // element 0 occupies the most-significant slot
    for (int k = 0; k < NE; k++)
      if (acc && idx_q == 4'(k)) begin
        if (state_q == LOAD_A) mat_a_d[ELEM_W*(NE-k)-1 -: ELEM_W] = in_data;
        else mat_b_d[ELEM_W*(NE-k)-1 -: ELEM_W] = in_data;
      end
    if (clear) begin
      state_d = LOAD_A;
      idx_d = '0;
    end else if (acc) begin
      idx_d = last ? 4'd0 : idx_q + 4'd1;
      if (last) state_d = state_q == LOAD_A ? LOAD_B : FULL;
    end else if (state_q == FULL && out_ready) state_d = LOAD_A;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= LOAD_A;
      idx_q <= '0;
      mat_a_q <= '0;
      mat_b_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
    end
  // held low while in reset so the source cannot believe an element was taken
  assign in_ready = rst_n && state_q != FULL;
  assign out_valid = state_q == FULL;
  assign mat_a = mat_a_q;
  assign mat_b = mat_b_q;
  assign elem_idx = idx_q;
  assign phase = state_q;
endmodule
